// File: rtl/bankgroup_access_ctrl_pkg.sv
// Shared encodings and default widths for the bankgroup access sequencer.
package bankgroup_access_ctrl_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int FIFO_NUM   = 3;

  typedef enum logic [1:0] {
    OP_RWR  = 2'b00,
    OP_RRD  = 2'b01,
    OP_PUSH = 2'b10,
    OP_POP  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_FLUSH, S_GAP
  } state_e;

  typedef struct packed {
    op_e        op;
    logic [1:0] fifo;
  } req_t;
endpackage

// File: rtl/bankgroup_rsp_slot.sv
// One-entry response holding register; payload stays frozen until the consumer takes it.
module bankgroup_rsp_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_err,
  input  logic [DATA_W-1:0] load_data,
  input  logic              rsp_ready,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_data
);
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp_err   <= load_err;
      rsp_data  <= load_data;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/bankgroup_access_ctrl.sv
// Single-outstanding sequencer turning valid/ready requests into registered bankgroup controls.
module bankgroup_access_ctrl
  import bankgroup_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [1:0]        req_fifo,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic              flush_req,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              bg_en,
  output logic              bg_we,
  output logic              bg_re,
  output logic              bg_pattern,
  output logic              bg_flush,
  output logic [1:0]        bg_fifo_sel,
  output logic [ADDR_W-1:0] bg_addr,
  output logic [DATA_W-1:0] bg_din,
  input  logic [DATA_W-1:0] bg_dout
);
  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  state_e      state;
  logic [2:0]  cnt;
  logic        flush_pend;
  req_t        req;
  logic        accept, illegal, is_wr;
  logic        slot_load, slot_err;
  logic [DATA_W-1:0] slot_data;

  assign req       = '{op: op_e'(req_op), fifo: req_fifo};
  assign req_ready = rst && (state == S_IDLE) && !flush_pend && !flush_req;
  assign accept    = req_valid && req_ready;
  assign illegal   = req.op[1] && (req.fifo >= 2'(FIFO_NUM));
  assign is_wr     = (req.op == OP_RWR) || (req.op == OP_PUSH);

  // Illegal FIFO requests answer immediately with an all-ones error response.
  always_comb begin
    slot_load = 1'b0;
    slot_err  = 1'b0;
    slot_data = bg_dout;
    if (state == S_IDLE && accept && illegal) begin
      slot_load = 1'b1;
      slot_err  = 1'b1;
      slot_data = '1;
    end else if (state == S_WAIT && cnt == 3'd0) begin
      slot_load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= 3'd0;
      flush_pend  <= 1'b0;
      bg_en       <= 1'b0;
      bg_we       <= 1'b0;
      bg_re       <= 1'b0;
      bg_pattern  <= 1'b0;
      bg_flush    <= 1'b0;
      bg_fifo_sel <= 2'd0;
      bg_addr     <= '0;
      bg_din      <= '0;
    end else begin
      bg_en    <= 1'b0;
      bg_we    <= 1'b0;
      bg_re    <= 1'b0;
      bg_flush <= 1'b0;
      if (flush_req) flush_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          if (flush_pend || flush_req) begin
            state      <= S_FLUSH;
            bg_flush   <= 1'b1;
            flush_pend <= 1'b0;
          end else if (accept) begin
            if (illegal) begin
              state <= S_RESP;
            end else begin
              state      <= S_ISSUE;
              bg_en      <= 1'b1;
              bg_we      <= is_wr;
              bg_re      <= !is_wr;
              bg_pattern <= req.op[1];
              if (req.op[1]) bg_fifo_sel <= req.fifo;
              else           bg_addr     <= req_addr;
              if (is_wr)     bg_din      <= req_data;
            end
          end
        end
        S_ISSUE: begin
          if (bg_re) begin
            state <= S_WAIT;
            cnt   <= CNT_INIT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt == 3'd0) state <= S_RESP;
          else             cnt   <= cnt - 3'd1;
        end
        S_RESP:  if (rsp_ready) state <= S_IDLE;
        S_FLUSH: state <= S_GAP;
        S_GAP:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  bankgroup_rsp_slot #(.DATA_W(DATA_W)) u_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (slot_load),
    .load_err  (slot_err),
    .load_data (slot_data),
    .rsp_ready (rsp_ready),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_data  (rsp_data)
  );
endmodule

// File: tb/tb_bankgroup_access_ctrl.sv
// Directed bench with a behavioral bankgroup (RAM + three FIFOs, one-cycle read latency).
module tb_bankgroup_access_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_op, req_fifo;
  logic [9:0]  req_addr;
  logic [31:0] req_data;
  logic        flush_req, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic        bg_en, bg_we, bg_re, bg_pattern, bg_flush;
  logic [1:0]  bg_fifo_sel;
  logic [9:0]  bg_addr;
  logic [31:0] bg_din;
  logic [31:0] bg_dout = '0;

  int passed = 0;
  int total  = 0;
  int en_cnt = 0;

  always #5 clk = ~clk;

  bankgroup_access_ctrl #(.ADDR_W(10), .DATA_W(32), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_fifo(req_fifo), .req_addr(req_addr), .req_data(req_data),
    .flush_req(flush_req), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .bg_en(bg_en), .bg_we(bg_we),
    .bg_re(bg_re), .bg_pattern(bg_pattern), .bg_flush(bg_flush),
    .bg_fifo_sel(bg_fifo_sel), .bg_addr(bg_addr), .bg_din(bg_din), .bg_dout(bg_dout)
  );

  // Bankgroup model: writes land on the issue edge, read data appears the cycle after issue.
  logic [31:0] mem [0:1023];
  logic [31:0] fq0[$], fq1[$], fq2[$];
  always @(posedge clk) begin
    if (bg_en) en_cnt <= en_cnt + 1;
    if (bg_en && bg_we) begin
      if (!bg_pattern) mem[bg_addr] = bg_din;
      else case (bg_fifo_sel)
        2'd0:    fq0.push_back(bg_din);
        2'd1:    fq1.push_back(bg_din);
        default: fq2.push_back(bg_din);
      endcase
    end
    if (bg_en && bg_re) begin
      if (!bg_pattern) bg_dout <= mem[bg_addr];
      else case (bg_fifo_sel)
        2'd0:    bg_dout <= (fq0.size() > 0) ? fq0.pop_front() : 32'hFFFF_FFFF;
        2'd1:    bg_dout <= (fq1.size() > 0) ? fq1.pop_front() : 32'hFFFF_FFFF;
        default: bg_dout <= (fq2.size() > 0) ? fq2.pop_front() : 32'hFFFF_FFFF;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Holds a request for one edge; returns #1 after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [1:0] f,
                      input logic [9:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_op = op; req_fifo = f; req_addr = a; req_data = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
  endtask

  int en_before;

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_fifo = 2'd0;
    req_addr = '0; req_data = '0; flush_req = 1'b0; rsp_ready = 1'b0;
    repeat (3) tick();
    chk("rst_ready",   32'(req_ready), 32'd0);
    chk("rst_bg_en",   32'(bg_en), 32'd0);
    chk("rst_flush",   32'(bg_flush), 32'd0);
    chk("rst_rspv",    32'(rsp_valid), 32'd0);
    chk("rst_rspd",    rsp_data, 32'd0);
    chk("rst_fsel",    32'(bg_fifo_sel), 32'd0);
    rst = 1'b1;
    tick();
    chk("rel_ready",   32'(req_ready), 32'd1);
    chk("rel_addr",    32'(bg_addr), 32'd0);

    // random write then read-back
    send(2'b00, 2'd0, 10'h005, 32'hA5A5_0001);
    chk("wr_en",   32'(bg_en), 32'd1);
    chk("wr_we",   32'(bg_we), 32'd1);
    chk("wr_re",   32'(bg_re), 32'd0);
    chk("wr_addr", 32'(bg_addr), 32'h005);
    chk("wr_din",  bg_din, 32'hA5A5_0001);
    chk("wr_pat",  32'(bg_pattern), 32'd0);
    chk("wr_busy", 32'(req_ready), 32'd0);
    tick();
    chk("wr_we_off", 32'(bg_we), 32'd0);
    chk("wr_addr_hold", 32'(bg_addr), 32'h005);
    chk("wr_no_rsp", 32'(rsp_valid), 32'd0);
    send(2'b01, 2'd0, 10'h005, 32'd0);
    chk("rd_re", 32'(bg_re), 32'd1);
    tick();
    chk("rd_lat1", 32'(rsp_valid), 32'd0);
    tick();
    chk("rd_valid", 32'(rsp_valid), 32'd1);
    chk("rd_data",  rsp_data, 32'hA5A5_0001);
    chk("rd_err",   32'(rsp_err), 32'd0);
    take_rsp();
    chk("rd_ready_back", 32'(req_ready), 32'd1);

    // FIFO pushes and stalled pops
    send(2'b10, 2'd1, 10'h000, 32'h11);
    chk("push_pat",  32'(bg_pattern), 32'd1);
    chk("push_fsel", 32'(bg_fifo_sel), 32'd1);
    chk("push_din",  bg_din, 32'h11);
    tick();
    send(2'b10, 2'd1, 10'h000, 32'h22);
    tick();
    send(2'b11, 2'd1, 10'h000, 32'd0);
    chk("pop_re", 32'(bg_re), 32'd1);
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      chk("pop1_valid", 32'(rsp_valid), 32'd1);
      chk("pop1_data",  rsp_data, 32'h11);
      chk("pop1_stall", 32'(req_ready), 32'd0);
      tick();
    end
    take_rsp();
    send(2'b11, 2'd1, 10'h000, 32'd0);
    tick(); tick();
    chk("pop2_data", rsp_data, 32'h22);
    chk("pop2_pat",  32'(bg_pattern), 32'd1);
    take_rsp();

    // illegal FIFO index
    en_before = en_cnt;
    send(2'b11, 2'd3, 10'h000, 32'd0);
    chk("ill_valid", 32'(rsp_valid), 32'd1);
    chk("ill_err",   32'(rsp_err), 32'd1);
    chk("ill_data",  rsp_data, 32'hFFFF_FFFF);
    chk("ill_en",    32'(bg_en), 32'd0);
    take_rsp();
    chk("ill_no_en", 32'(en_cnt - en_before), 32'd0);

    // flush wins over a simultaneous request
    flush_req = 1'b1;
    req_valid = 1'b1; req_op = 2'b00; req_fifo = 2'd0; req_addr = 10'h007; req_data = 32'h77;
    #1;
    chk("fl_ready", 32'(req_ready), 32'd0);
    tick();
    flush_req = 1'b0;
    chk("fl_pulse", 32'(bg_flush), 32'd1);
    chk("fl_en",    32'(bg_en), 32'd0);
    tick();
    chk("fl_gap",   32'(bg_flush), 32'd0);
    chk("fl_gap_rdy", 32'(req_ready), 32'd0);
    tick();
    chk("fl_idle_rdy", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("fl_acc_en",   32'(bg_en), 32'd1);
    chk("fl_acc_addr", 32'(bg_addr), 32'h007);
    chk("fl_acc_pat",  32'(bg_pattern), 32'd0);
    tick();

    // reset in the middle of a read
    send(2'b01, 2'd0, 10'h007, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("mr_rspv",  32'(rsp_valid), 32'd0);
    chk("mr_flush", 32'(bg_flush), 32'd0);
    chk("mr_addr",  32'(bg_addr), 32'd0);
    chk("mr_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_no_rsp", 32'(rsp_valid), 32'd0);
    end
    send(2'b00, 2'd0, 10'h009, 32'h99);
    chk("mr_wr_en",   32'(bg_we), 32'd1);
    chk("mr_wr_addr", 32'(bg_addr), 32'h009);
    chk("mr_wr_din",  bg_din, 32'h99);
    tick();
    chk("mr_wr_done", 32'(req_ready), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
